hero_sprite_fetch: RTL and testbench

- Upstream stage of the hero colour palette lookup.
- For every VGA pixel it decides whether the pixel falls inside the hero sprite box and generates the sprite ROM address for the current running-animation frame, applying horizontal mirroring when the hero faces left.
- It realigns the ROM's 3-bit palette index with a valid/opaque flag, ready for the palette module and the colour mapper.
- It owns the running animation sequencer (frames R1→R2→R3), which advances on vertical-blank ticks.

---
 rtl/hero_pkg.sv | 25 ++
 rtl/hero_anim_seq.sv | 59 +++++
 rtl/hero_sprite_fetch.sv | 116 +++++++++++
 tb/tb_hero_sprite_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hero_pkg.sv
// Shared constants and types for the hero sprite fetch path.
package hero_pkg;

  localparam int SPR_W      = 32;
  localparam int SPR_H      = 48;
  localparam int N_FRAMES   = 3;
  localparam int FRAME_HOLD = 6;

  localparam logic [2:0] TRANSP_IDX = 3'd0;

  typedef logic [1:0] anim_frame_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } anim_state_t;

  // Smallest ROM address width that holds every frame back-to-back.
  function automatic int addr_width(input int w, input int h, input int n);
    return $clog2(w * h * n);
  endfunction

  localparam int ADDR_W = addr_width(SPR_W, SPR_H, N_FRAMES);

endpackage

// File: rtl/hero_anim_seq.sv
// Running animation sequencer: IDLE/RUN state, hold counter and frame counter.
// Everything advances only on frame_tick; between ticks the state is frozen.
module hero_anim_seq
  import hero_pkg::*;
#(
  parameter int N_FRAMES   = hero_pkg::N_FRAMES,
  parameter int FRAME_HOLD = hero_pkg::FRAME_HOLD
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        running,
  output anim_frame_t anim_frame,
  output anim_state_t state
);

  localparam int CW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  anim_state_t   state_n;
  logic [CW-1:0] cnt, cnt_n;
  anim_frame_t   frame_n;

  // State, hold counter and frame register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      anim_frame <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      anim_frame <= frame_n;
    end
  end

  // Next-state: a tick with running=1 always counts (including the tick that
  // leaves IDLE); a tick with running=0 returns to IDLE with frame and counter cleared.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frame_n = anim_frame;
    if (frame_tick) begin
      if (!running) begin
        state_n = S_IDLE;
        cnt_n   = '0;
        frame_n = '0;
      end else begin
        state_n = S_RUN;
        if (cnt == CW'(FRAME_HOLD - 1)) begin
          cnt_n   = '0;
          frame_n = (anim_frame == anim_frame_t'(N_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hero_sprite_fetch.sv
// Hero sprite fetch: box test, mirrored ROM addressing and index realignment.
// Stream interface: no handshake; one pixel per Clk, qualified by de, and the
// pix_* outputs follow their pixel by exactly two cycles. rom_data must be the
// ROM word for rom_addr during the cycle after rom_addr is registered.
module hero_sprite_fetch
  import hero_pkg::*;
#(
  parameter int         SPR_W      = hero_pkg::SPR_W,
  parameter int         SPR_H      = hero_pkg::SPR_H,
  parameter int         N_FRAMES   = hero_pkg::N_FRAMES,
  parameter int         FRAME_HOLD = hero_pkg::FRAME_HOLD,
  parameter logic [2:0] TRANSP_IDX = hero_pkg::TRANSP_IDX,
  parameter int         ADDR_W     = 13
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              running,
  input  logic              face_left,
  input  logic [9:0]        hero_x,
  input  logic [9:0]        hero_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              de,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic              pix_valid,
  output logic              pix_opaque,
  output logic [2:0]        pix_index,
  output anim_frame_t       anim_frame
);

  // Shadow copies taken at frame_tick; pixel math never sees live inputs.
  logic [9:0]  hx, hy;
  logic        face_sh, run_sh;

  anim_frame_t seq_frame, frame_px;
  anim_state_t seq_state;

  logic [10:0]       x11, y11, hx11, hy11, dx, dy, col;
  logic              inside_c;
  logic [ADDR_W-1:0] addr_c;
  logic              de_d1, inside_d1;

  hero_anim_seq #(
    .N_FRAMES  (N_FRAMES),
    .FRAME_HOLD(FRAME_HOLD)
  ) u_seq (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .running   (running),
    .anim_frame(seq_frame),
    .state     (seq_state)
  );

  // IDLE always reports frame 0; the shadow run flag gates addressing the same way.
  assign anim_frame = (seq_state == S_RUN) ? seq_frame : '0;
  assign frame_px   = run_sh ? anim_frame : '0;

  // Latch position, facing and run state at the frame boundary.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hx      <= '0;
      hy      <= '0;
      face_sh <= 1'b0;
      run_sh  <= 1'b0;
    end else if (frame_tick) begin
      hx      <= hero_x;
      hy      <= hero_y;
      face_sh <= face_left;
      run_sh  <= running;
    end
  end

  // Box test and address math at 11 bits so hx+SPR_W past 1023 cannot wrap.
  always_comb begin
    x11      = {1'b0, DrawX};
    y11      = {1'b0, DrawY};
    hx11     = {1'b0, hx};
    hy11     = {1'b0, hy};
    dx       = x11 - hx11;
    dy       = y11 - hy11;
    inside_c = de && (x11 >= hx11) && (x11 < hx11 + 11'(SPR_W))
                  && (y11 >= hy11) && (y11 < hy11 + 11'(SPR_H));
    col      = face_sh ? (11'(SPR_W - 1) - dx) : dx;
    addr_c   = ADDR_W'(int'(frame_px) * SPR_W * SPR_H + int'(dy) * SPR_W + int'(col));
  end

  // Stage 1: register ROM address (held outside the box), de and inside.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      de_d1     <= 1'b0;
      inside_d1 <= 1'b0;
    end else begin
      de_d1     <= de;
      inside_d1 <= inside_c;
      if (inside_c) rom_addr <= addr_c;
    end
  end

  // Stage 2: align the ROM index with valid/opaque flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid  <= 1'b0;
      pix_opaque <= 1'b0;
      pix_index  <= '0;
    end else begin
      pix_valid  <= de_d1;
      pix_index  <= inside_d1 ? rom_data : TRANSP_IDX;
      pix_opaque <= inside_d1 && (rom_data != TRANSP_IDX);
    end
  end

endmodule

// File: tb/tb_hero_sprite_fetch.sv
// Self-checking bench for hero_sprite_fetch.
module tb_hero_sprite_fetch;
  import hero_pkg::*;

  localparam int AW = 13;
  localparam int PW = 37;       // {due[31:0], valid, opaque, index[2:0]}
  localparam int QW = 32 + AW;  // {due[31:0], addr}

  // ---------------- clock / reset ----------------
  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_tick = 1'b0, running = 1'b0, face_left = 1'b0, de = 1'b0;
  logic [9:0]    hero_x = '0, hero_y = '0, DrawX = '0, DrawY = '0;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_data, pix_index;
  logic          pix_valid, pix_opaque;
  anim_frame_t   anim_frame;

  always #5 Clk = ~Clk;

  hero_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .running(running),
    .face_left(face_left), .hero_x(hero_x), .hero_y(hero_y),
    .DrawX(DrawX), .DrawY(DrawY), .de(de), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_opaque(pix_opaque),
    .pix_index(pix_index), .anim_frame(anim_frame)
  );

  // ROM model: contents are a fixed hash of the address.
  function automatic logic [2:0] rom_fn(input logic [AW-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ {2'b00, a[12]};
  endfunction

  assign rom_data = rom_fn(rom_addr);

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [PW-1:0] exp_q[$];
  logic [QW-1:0] addr_q[$];
  logic [PW-1:0] pe;
  logic [QW-1:0] ae;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop expectations that fall due on this edge and compare 1 ns after it.
  always @(posedge Clk) begin
    cyc = cyc + 1;
    #1;
    while (addr_q.size() > 0 && addr_q[0][QW-1 -: 32] <= 32'(cyc)) begin
      ae = addr_q.pop_front();
      check("rom_addr", 32'(rom_addr), 32'(ae[AW-1:0]));
    end
    while (exp_q.size() > 0 && exp_q[0][PW-1 -: 32] <= 32'(cyc)) begin
      pe = exp_q.pop_front();
      check("pix_valid",  32'(pix_valid),  32'(pe[4]));
      check("pix_opaque", 32'(pix_opaque), 32'(pe[3]));
      check("pix_index",  32'(pix_index),  32'(pe[2:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic d,
                       input logic t, input logic ein, input logic [AW-1:0] eaddr);
    logic [2:0] idx;
    @(negedge Clk);
    DrawX = x; DrawY = y; de = d; frame_tick = t;
    idx = ein ? rom_fn(eaddr) : TRANSP_IDX;
    if (ein) addr_q.push_back({32'(cyc + 1), eaddr});
    exp_q.push_back({32'(cyc + 2), d, ein && (idx != TRANSP_IDX), idx});
  endtask

  task automatic idle();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, AW'(0));
  endtask

  // Tick with de=0; returns just after the edge that consumed the tick.
  task automatic pulse_tick(input logic run);
    running = run;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, AW'(0));
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
    check({tag, "_pix_valid"},  32'(pix_valid),  32'd0);
    check({tag, "_pix_opaque"}, 32'(pix_opaque), 32'd0);
    check({tag, "_pix_index"},  32'(pix_index),  32'd0);
    check({tag, "_anim_frame"}, 32'(anim_frame), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [9:0]    hx, hy;
    logic          face;
    logic [9:0]    x, y;
    logic          d;
    logic          ein;
    logic [AW-1:0] addr;
  } vec_t;

  function automatic vec_t mk(input int hx, input int hy, input int face, input int x,
                              input int y, input int d, input int ein, input int addr);
    vec_t v;
    v.hx = 10'(hx); v.hy = 10'(hy); v.face = 1'(face);
    v.x = 10'(x); v.y = 10'(y); v.d = 1'(d); v.ein = 1'(ein); v.addr = AW'(addr);
    return v;
  endfunction

  vec_t vecs[14];

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk( 100, 200, 0,  100, 200, 1, 1,    0);  // top-left corner
    vecs[1]  = mk( 100, 200, 0,  131, 247, 1, 1, 1535);  // bottom-right corner
    vecs[2]  = mk( 100, 200, 1,  131, 247, 1, 1, 1504);  // mirrored
    vecs[3]  = mk( 100, 200, 0,  132, 247, 1, 0,    0);  // one past right edge
    vecs[4]  = mk( 100, 200, 1,  100, 247, 1, 1, 1535);  // mirrored left column
    vecs[5]  = mk(1000,  10, 0, 1023,  10, 1, 1,   23);  // near right screen edge
    vecs[6]  = mk(1000,  10, 0,    0,  10, 1, 0,    0);  // no wrap to column 0
    vecs[7]  = mk(1000,  10, 0, 1023,  57, 1, 1, 1527);  // last row
    vecs[8]  = mk(1000,  10, 0, 1023,  58, 1, 0,    0);  // one past last row
    vecs[9]  = mk( 100, 200, 0,   99, 200, 1, 0,    0);  // one before left edge
    vecs[10] = mk( 100, 200, 0,  100, 200, 0, 0,    0);  // de=0 inside box
    vecs[11] = mk( 100, 450, 0,  110, 479, 1, 1,  938);  // bottom clipping
    vecs[12] = mk( 100, 200, 1,  105, 210, 1, 1,  346);  // mirrored interior
    vecs[13] = mk(1000,  10, 1, 1023,  10, 1, 1,    8);  // mirrored at screen edge

    // Reset state
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Reset_n = 1'b1;

    // Table-driven pixel vectors, each preceded by a latching tick (running=0)
    foreach (vecs[i]) begin
      hero_x = vecs[i].hx; hero_y = vecs[i].hy; face_left = vecs[i].face;
      pulse_tick(1'b0);
      drive(vecs[i].x, vecs[i].y, vecs[i].d, 1'b0, vecs[i].ein, vecs[i].addr);
    end
    idle();
    check("anim_frame_idle", 32'(anim_frame), 32'd0);

    // Animation: 18 ticks running, FRAME_HOLD=6, 3 frames
    hero_x = 10'd100; hero_y = 10'd200; face_left = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      pulse_tick(1'b1);
      check($sformatf("anim_frame_tick%0d", i), 32'(anim_frame), 32'((i / 6) % 3));
      idle();
    end
    for (int i = 1; i <= 7; i++) begin
      pulse_tick(1'b1);
      idle();
    end
    check("anim_frame_run7", 32'(anim_frame), 32'd1);
    drive(10'd100, 10'd200, 1'b1, 1'b0, 1'b1, AW'(1536));  // frame 1 base address
    idle();
    pulse_tick(1'b0);
    check("anim_frame_drop", 32'(anim_frame), 32'd0);
    idle();
    drive(10'd100, 10'd200, 1'b1, 1'b0, 1'b1, AW'(0));

    // Mid-line hero_x change, then a tick coincident with a pixel
    hero_x = 10'd300;
    drive(10'd105, 10'd200, 1'b1, 1'b0, 1'b1, AW'(5));   // old hx still in use
    drive(10'd106, 10'd200, 1'b1, 1'b1, 1'b1, AW'(6));   // tick: this pixel uses old hx
    drive(10'd305, 10'd200, 1'b1, 1'b0, 1'b1, AW'(5));   // new hx now in effect
    drive(10'd106, 10'd200, 1'b1, 1'b0, 1'b0, AW'(0));   // outside the new box
    idle();

    // Reach frame 1, stream pixels, then reset mid-line
    for (int i = 1; i <= 6; i++) begin
      pulse_tick(1'b1);
      idle();
    end
    check("anim_frame_pre_reset", 32'(anim_frame), 32'd1);
    for (int x = 300; x < 304; x++)
      drive(10'(x), 10'd200, 1'b1, 1'b0, 1'b1, AW'(1536 + x - 300));
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    de = 1'b0; frame_tick = 1'b0; running = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Shadows are cleared: box sits at (0,0), frame 0, not mirrored
    idle();
    for (int x = 0; x < 8; x++)
      drive(10'(x), 10'd0, 1'b1, 1'b0, 1'b1, AW'(x));
    repeat (3) idle();

    // Drain with a bounded wait
    for (int w = 0; w < 20 && (exp_q.size() > 0 || addr_q.size() > 0); w++)
      @(posedge Clk);
    @(negedge Clk);
    check("queue_drained", 32'(exp_q.size() + addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
